pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter stage of the CPU datapath. It holds the current instruction address, advances, jumps or calls/returns under control-unit strobes, and drives the address seen by the instruction-memory fetch stage. It is built as a clocked register bank on the team's edge-triggered flip-flops, plus an optional hardware return-address stack.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of the program counter and all addresses
- STACK_DEPTH, 4, number of return-address entries (power of two, ≥2)

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  reset, synchronous, active-low
- inc  input  1  advance pc by 1
- load  input  1  jump: pc <= load_addr
- call  input  1  push return address (pc+1), jump to load_addr
- ret  input  1  pop top of stack into pc
- load_addr  input  ADDR_WIDTH  jump/call target
- pc  output  ADDR_WIDTH  current instruction address (registered)
- stack_full  output  1  stack holds STACK_DEPTH entries
- stack_empty  output  1  stack holds 0 entries
- stack_err  output  1  one-cycle pulse: overflow or underflow attempted

## Operation
- All outputs are registered. Reset (reset==0 at posedge): pc=0, sp=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- Fixed per-cycle priority: ret > call > load > inc > hold. Exactly one action takes effect per edge. Lower-priority strobes in the same cycle are ignored.
- inc: pc <= pc+1, modulo 2^ADDR_WIDTH. All-ones wraps to 0 with no flag.
- load: pc <= load_addr.
- call, not full: stack[sp] <= pc+1 (wrapped), sp <= sp+1, pc <= load_addr.
- call when full: pc, sp and stack are unchanged; stack_err=1 on the next cycle.
- ret, not empty: pc <= stack[sp-1], sp <= sp-1.
- ret when empty: pc and sp are unchanged; stack_err=1 on the next cycle.
- sp has range 0..STACK_DEPTH and is held in $clog2(STACK_DEPTH)+1 bits.
  - stack_empty = (sp==0), stack_full = (sp==STACK_DEPTH), both registered alongside sp.
- stack_err is high for exactly one cycle per offending edge. Back-to-back illegal ops give back-to-back pulses.

## Timing
- Single-cycle latency: a strobe sampled at edge N is reflected on pc, flags and stack_err after edge N.
- No handshake. The control unit may assert strobes every cycle.
- Reset has priority over all strobes. Asserting reset mid-call discards the push, and pc=0 after that edge.
- Strobes are sampled only at posedge. Glitches between edges have no effect.

## Configuration
- PC_CALL_STACK_EN defined: return-address stack, call/ret semantics and flags behave as described above.
- PC_CALL_STACK_EN undefined:
  - No stack storage is built.
  - call behaves exactly as load (jump, no push).
  - ret is ignored (hold, unless a lower-priority strobe acts).
  - Outputs are tied: stack_empty=1, stack_full=0, stack_err=0.
  - Ports remain present so the control unit is unchanged.

## Structure
- Shared CPU package holds:
  - the default ADDR_WIDTH (shared with fetch and memory stages)
  - the STACK_DEPTH default
  - the action-select encoding (HOLD, INC, LOAD, CALL, RET) used by the priority resolver
- Sub-module pc_stack: the LIFO. Contains storage, sp, full/empty and the error pulse, and takes push/pop/push_data. It is instantiated only under PC_CALL_STACK_EN.
- The pc register and stack entries are multi-bit banks of the existing flip-flop primitive, with reset wired to the same synchronous active-low reset.

## Test plan
- Reset then 3× inc -> pc=0,1,2,3, stack_empty=1. inc from pc=8'hFF -> pc=8'h00, stack_err=0.
- pc=8'h10, call with load_addr=8'h40 -> pc=8'h40, stack_empty=0. Then ret -> pc=8'h11, stack_empty=1.
- 4 calls from pc=0x01, 0x21, 0x31, 0x41 (targets 0x20, 0x30, 0x40, 0x50) -> stack_full=1. 5th call to 8'h60 -> pc stays 0x50, stack_err=1 for one cycle. 4 rets -> pc=0x42, 0x32, 0x22, 0x02.
- ret on empty stack at pc=8'h05 -> pc=8'h05, stack_err=1 for one cycle, then 0.
- ret+call+load+inc together with a non-empty stack (top 8'h33) -> pc=8'h33, sp decremented, no push.
- reset=0 on the same edge as call -> pc=0, sp=0, stack_empty=1. Following ret -> stack_err=1.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared CPU definitions for the program-counter stage.
//   ADDR_WIDTH_DEF  - default address width (shared with fetch/memory stages)
//   STACK_DEPTH_DEF - default return-address stack depth
//   act_e           - action-select encoding produced by the priority resolver
//   pc_strobe_t     - control-unit strobe bundle
//   resolve_act     - fixed priority ret > call > load > inc > hold
package pc_unit_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 8;
    localparam int unsigned STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_INC  = 3'd1,
        ACT_LOAD = 3'd2,
        ACT_CALL = 3'd3,
        ACT_RET  = 3'd4
    } act_e;

    typedef struct packed {
        logic ret;
        logic call;
        logic load;
        logic inc;
    } pc_strobe_t;

    // Pick exactly one action per cycle; lower-priority strobes are dropped.
    function automatic act_e resolve_act(pc_strobe_t s);
        if (s.ret)       return ACT_RET;
        else if (s.call) return ACT_CALL;
        else if (s.load) return ACT_LOAD;
        else if (s.inc)  return ACT_INC;
        else             return ACT_HOLD;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control-unit <-> program-counter stage signals.
//   master (control unit): drives inc/load/call/ret/load_addr, observes pc and flags
//   slave  (pc_unit):      consumes strobes, drives pc, stack_full, stack_empty, stack_err
interface pc_unit_if
    import pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  inc;
    logic                  load;
    logic                  call;
    logic                  ret;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  stack_err;

    modport master (
        output inc, load, call, ret, load_addr,
        input  pc, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  inc, load, call, ret, load_addr,
        output pc, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/pc_stack.sv
// pc_stack: return-address LIFO for pc_unit.
//   clk, reset (sync, active-low)
//   push_i / pop_i   - push or pop request (never both in one cycle)
//   push_data_i      - value to push
//   top_c_o          - combinational read of the top entry (stack[sp-1])
//   full_o / empty_o - registered sp==DEPTH / sp==0
//   err_o            - registered one-cycle pulse on push-when-full or pop-when-empty
module pc_stack
    import pc_unit_pkg::*;
#(
    parameter int unsigned W     = ADDR_WIDTH_DEF,
    parameter int unsigned DEPTH = STACK_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_c_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         err_o
);
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned SPW = IW + 1;

    logic [W-1:0]   mem_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic           full_q, empty_q, err_q, err_d;
    logic           do_push, do_pop;

    // Gate requests against the current flags; illegal requests only raise err.
    always_comb begin
        do_push = push_i && !full_q;
        do_pop  = pop_i && !empty_q;
        err_d   = (push_i && full_q) || (pop_i && empty_q);
        sp_d    = sp_q;
        if (do_push)     sp_d = sp_q + SPW'(1);
        else if (do_pop) sp_d = sp_q - SPW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sp_q    <= sp_d;
            full_q  <= (sp_d == SPW'(DEPTH));
            empty_q <= (sp_d == '0);
            err_q   <= err_d;
            if (do_push) mem_q[sp_q[IW-1:0]] <= push_data_i;
        end
    end

    assign top_c_o = mem_q[IW'(sp_q - SPW'(1))];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign err_o   = err_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage (advance / jump / call / return).
//   clk, reset (sync, active-low)
//   bus (pc_unit_if.slave): inc, load, call, ret, load_addr in; pc, stack_full,
//                           stack_empty, stack_err out (all registered)
// Build option: PC_CALL_STACK_EN adds the return-address stack (pc_stack).
// Without it call acts as load, ret is ignored and the stack flags are tied.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave bus
);
`ifdef PC_CALL_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic [ADDR_WIDTH-1:0] stk_top;
    logic                  stk_full, stk_empty;
    pc_strobe_t            strb;
    act_e                  act;

    // Resolve the single action for this edge; ret/call fold away without a stack.
    always_comb begin
        strb.ret  = bus.ret && STACK_EN;
        strb.call = bus.call;
        strb.load = bus.load;
        strb.inc  = bus.inc;
        act       = resolve_act(strb);
        if (!STACK_EN && act == ACT_CALL) act = ACT_LOAD;
    end

    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    always_comb begin
        pc_d = pc_q;
        case (act)
            ACT_INC:  pc_d = pc_inc;
            ACT_LOAD: pc_d = bus.load_addr;
            ACT_CALL: pc_d = stk_full ? pc_q : bus.load_addr;
            ACT_RET:  pc_d = stk_empty ? pc_q : stk_top;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    assign bus.pc = pc_q;

`ifdef PC_CALL_STACK_EN
    logic stk_err;

    pc_stack #(
        .W     (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (act == ACT_CALL),
        .pop_i       (act == ACT_RET),
        .push_data_i (pc_inc),
        .top_c_o     (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty),
        .err_o       (stk_err)
    );

    assign bus.stack_full  = stk_full;
    assign bus.stack_empty = stk_empty;
    assign bus.stack_err   = stk_err;
`else
    assign stk_top         = '0;
    assign stk_full        = 1'b0;
    assign stk_empty       = 1'b1;
    assign bus.stack_full  = 1'b0;
    assign bus.stack_empty = 1'b1;
    assign bus.stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (both build options).
module tb_pc_unit;
`ifdef PC_CALL_STACK_EN
    localparam bit E = 1'b1;
`else
    localparam bit E = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    pc_unit_if bus ();

    pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic tick(input logic r, input logic i, input logic l,
                        input logic c, input logic rt, input logic [7:0] a);
        reset         = r;
        bus.inc       = i;
        bus.load      = l;
        bus.call      = c;
        bus.ret       = rt;
        bus.load_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [7:0] exp);
        chk(tag, 32'(bus.pc), 32'(exp));
    endtask

    initial begin
        reset = 1'b0;
        bus.inc = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
        bus.load_addr = 8'h00;

        // Reset state
        tick(0, 0, 0, 0, 0, 8'h00);
        tick(0, 0, 0, 0, 0, 8'h00);
        chk_pc("rst_pc", 8'h00);
        chk("rst_empty", 32'(bus.stack_empty), 32'd1);
        chk("rst_full", 32'(bus.stack_full), 32'd0);
        chk("rst_err", 32'(bus.stack_err), 32'd0);

        // Increment
        tick(1, 1, 0, 0, 0, 8'h00); chk_pc("inc1", 8'h01);
        tick(1, 1, 0, 0, 0, 8'h00); chk_pc("inc2", 8'h02);
        tick(1, 1, 0, 0, 0, 8'h00); chk_pc("inc3", 8'h03);
        chk("inc_empty", 32'(bus.stack_empty), 32'd1);
        tick(1, 0, 0, 0, 0, 8'h00); chk_pc("hold", 8'h03);

        // Wrap
        tick(1, 0, 1, 0, 0, 8'hFF); chk_pc("load_ff", 8'hFF);
        tick(1, 1, 0, 0, 0, 8'h00); chk_pc("wrap", 8'h00);
        chk("wrap_err", 32'(bus.stack_err), 32'd0);

        // load beats inc
        tick(1, 1, 1, 0, 0, 8'h20); chk_pc("load_over_inc", 8'h20);

        // Single call / ret
        tick(1, 0, 1, 0, 0, 8'h10);
        tick(1, 0, 0, 1, 0, 8'h40); chk_pc("call1", 8'h40);
        chk("call1_empty", 32'(bus.stack_empty), E ? 32'd0 : 32'd1);
        tick(1, 0, 0, 0, 1, 8'h00); chk_pc("ret1", E ? 8'h11 : 8'h40);
        chk("ret1_empty", 32'(bus.stack_empty), 32'd1);

        // Fill stack
        tick(1, 0, 1, 0, 0, 8'h01); tick(1, 0, 0, 1, 0, 8'h20);
        tick(1, 0, 1, 0, 0, 8'h21); tick(1, 0, 0, 1, 0, 8'h30);
        tick(1, 0, 1, 0, 0, 8'h31); tick(1, 0, 0, 1, 0, 8'h40);
        tick(1, 0, 1, 0, 0, 8'h41); tick(1, 0, 0, 1, 0, 8'h50);
        chk_pc("call4", 8'h50);
        chk("full4", 32'(bus.stack_full), E ? 32'd1 : 32'd0);
        chk("err4", 32'(bus.stack_err), 32'd0);
        tick(1, 0, 0, 1, 0, 8'h60); chk_pc("overflow_pc", E ? 8'h50 : 8'h60);
        chk("overflow_err", 32'(bus.stack_err), E ? 32'd1 : 32'd0);
        chk("overflow_full", 32'(bus.stack_full), E ? 32'd1 : 32'd0);
        tick(1, 0, 0, 0, 0, 8'h00);
        chk("overflow_err_clr", 32'(bus.stack_err), 32'd0);

        // Unwind
        tick(1, 0, 0, 0, 1, 8'h00); chk_pc("ret_a", E ? 8'h42 : 8'h60);
        chk("ret_a_full", 32'(bus.stack_full), 32'd0);
        tick(1, 0, 0, 0, 1, 8'h00); chk_pc("ret_b", E ? 8'h32 : 8'h60);
        tick(1, 0, 0, 0, 1, 8'h00); chk_pc("ret_c", E ? 8'h22 : 8'h60);
        tick(1, 0, 0, 0, 1, 8'h00); chk_pc("ret_d", E ? 8'h02 : 8'h60);
        chk("ret_d_empty", 32'(bus.stack_empty), 32'd1);
        chk("ret_d_err", 32'(bus.stack_err), 32'd0);

        // Underflow
        tick(1, 0, 1, 0, 0, 8'h05);
        tick(1, 0, 0, 0, 1, 8'h00); chk_pc("underflow_pc", 8'h05);
        chk("underflow_err", 32'(bus.stack_err), E ? 32'd1 : 32'd0);
        tick(1, 0, 0, 0, 1, 8'h00);
        chk("underflow_err_b2b", 32'(bus.stack_err), E ? 32'd1 : 32'd0);
        tick(1, 0, 0, 0, 0, 8'h00);
        chk("underflow_err_clr", 32'(bus.stack_err), 32'd0);
        chk_pc("underflow_hold", 8'h05);

        // All strobes together, stack top 0x33
        tick(1, 0, 1, 0, 0, 8'h32);
        tick(1, 0, 0, 1, 0, 8'h10); chk_pc("prio_setup", 8'h10);
        tick(1, 1, 1, 1, 1, 8'h77); chk_pc("prio_pc", E ? 8'h33 : 8'h77);
        chk("prio_empty", 32'(bus.stack_empty), 32'd1);
        tick(1, 0, 0, 0, 1, 8'h00); chk_pc("prio_nopush", E ? 8'h33 : 8'h77);
        chk("prio_nopush_err", 32'(bus.stack_err), E ? 32'd1 : 32'd0);

        // Reset on the same edge as call
        tick(1, 0, 1, 0, 0, 8'h10);
        tick(0, 0, 0, 1, 0, 8'h44); chk_pc("rst_call_pc", 8'h00);
        chk("rst_call_empty", 32'(bus.stack_empty), 32'd1);
        chk("rst_call_full", 32'(bus.stack_full), 32'd0);
        tick(1, 0, 0, 0, 1, 8'h00); chk_pc("rst_ret_pc", 8'h00);
        chk("rst_ret_err", 32'(bus.stack_err), E ? 32'd1 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
